rv32i_decode_execute_mem: RTL and testbench
===========================================

RV32I_DECODE_EXECUTE_MEM -- requirements
Module: rv32i_decode_execute_mem

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h0100_0000, meaning the byte address of data-memory byte 0 and the PC reset value.
REQ-002 SHALL have parameter MEM_BYTES, default 65536, meaning the data-memory size in bytes.
REQ-003 SHALL have ports:
- clk  input  1  — system clock, rising edge active.
- rst_n  input  1  — reset; asynchronous, active-low.
- instruction  input  32  — instruction word at the current PC.
- data_rs1, data_rs2  input  32 each  — register-file read data.
- PC  output  32  — current PC (registered).
- PC_next  output  32  — next PC (combinational).
- addr_rs1, addr_rs2, addr_rd  output  5 each  — register-file addresses (instr[19:15], [24:20], [11:7]).
- RegWE  output  1  — register write enable.
- wb_data  output  32  — write-back value.
- ALU_out  output  32  — ALU result, which is also the data-memory address.
- halt  output  1  — ECALL seen.

Function
REQ-004 SHALL decode RV32I: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM and OP (including SUB, SRA, SRAI), and ECALL; the design is single-cycle.
REQ-005 SHALL generate the immediate by format, sign-extended from instr[31]:
- I: [31:20]
- S: {[31:25],[11:7]}
- B: {[31],[7],[30:25],[11:8],0}
- U: {[31:12],12'b0}
- J: {[31],[19:12],[20],[30:21],0}
REQ-006 SHALL select ALU operand A = PC for AUIPC, JAL and branches, otherwise data_rs1.
REQ-007 SHALL select ALU operand B = data_rs2 for OP, otherwise the immediate.
REQ-008 SHALL support ALU ops ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, and LUI (pass operand B); shift amounts use B[4:0].
REQ-009 SHALL compute BrEq = (rs1==rs2) and BrLt as a signed compare, or unsigned for BLTU/BGEU.
REQ-010 SHALL set PC_next per instruction:
- Taken branch or JAL: ALU_out.
- JALR: ALU_out with bit0 cleared.
- ECALL: PC.
- All others: PC+4.
REQ-011 SHALL load PC <= PC_next on each rising clk edge.
REQ-012 SHALL select wb_data per instruction:
- Loads: memory read data.
- JAL and JALR: PC+4.
- All others: ALU_out.
REQ-013 SHALL assert RegWE for LUI, AUIPC, JAL, JALR, loads, OP-IMM and OP only when addr_rd != 0; RegWE SHALL be 0 otherwise.
REQ-014 SHALL provide data memory that is byte-addressed and little-endian at address ALU_out − MEM_BASE.
REQ-015 SHALL perform memory reads combinationally and memory writes on the rising clk edge when a store executes.
REQ-016 SHALL size memory accesses as follows:
- Byte for LB/LBU/SB; half for LH/LHU/SH; word for LW/SW.
- LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned accesses are performed bytewise, with no exception.
REQ-017 SHALL handle accesses outside [MEM_BASE, MEM_BASE+MEM_BYTES) as follows: reads return 32'hBADB_ADFF; writes are ignored.
REQ-018 SHALL treat any unrecognized opcode as a NOP: RegWE=0, no memory write, PC_next=PC+4.
REQ-019 SHALL assert halt combinationally while instruction is ECALL (32'h0000_0073); PC holds, RegWE=0, no memory write.
REQ-020 SHALL drive addr_rs1/addr_rs2/addr_rd from the instruction fields regardless of format.

Reset
REQ-021 SHALL reset asynchronously while rst_n=0: PC = MEM_BASE.
REQ-022 SHALL suppress memory writes while rst_n=0; memory contents are not cleared by reset.
REQ-023 SHALL drive all combinational outputs from the reset PC and the current inputs during reset.
REQ-024 SHALL resume on the first rising clk edge after rst_n rises; a reset asserted mid-operation aborts the in-flight store, and PC returns to MEM_BASE immediately.

Verification
REQ-025 SHALL pass this case: reset → PC=32'h0100_0000; then ADDI x5,x0,-1 → RegWE=1, addr_rd=5, wb_data=32'hFFFF_FFFF, PC_next=32'h0100_0004.
REQ-026 SHALL pass this case: data_rs1=32'h0100_0100, data_rs2=32'h8081_8283, SW x2,0(x1), then LB/LBU/LH/LHU/LW at offset 0 → wb_data = FFFF_FF83 / 0000_0083 / FFFF_8283 / 0000_8283 / 8081_8283.
REQ-027 SHALL pass this case: PC=32'h0100_0010, BLT with rs1=-1, rs2=1, imm=-16 → PC_next=32'h0100_0000. The same operands with BLTU → PC_next=32'h0100_0014.
REQ-028 SHALL pass this case: PC=32'h0100_0008, JALR x1,4(x6) with rs1=32'h0100_0021 → PC_next=32'h0100_0024, wb_data=32'h0100_000C, RegWE=1.
REQ-029 SHALL pass this case: LW from address 32'h0000_0000 → wb_data=32'hBADB_ADFF. SW to the same address → memory is unchanged.
REQ-030 SHALL pass this case: ECALL → halt=1, PC is unchanged over 3 clocks, RegWE=0. Asserting rst_n=0 mid-cycle → PC=MEM_BASE before the next edge.

Source files
------------

// File: rtl/rv32i_decode_execute_mem.sv
// rv32i_decode_execute_mem: single-cycle RV32I decode/execute stage with PC register and
// byte-addressed little-endian data memory; ECALL halts by holding the PC.
module rv32i_decode_execute_mem #(
  parameter logic [31:0] MEM_BASE  = 32'h0100_0000,
  parameter int          MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [31:0] data_rs1,
  input  logic [31:0] data_rs2,
  output logic [31:0] PC,
  output logic [31:0] PC_next,
  output logic [4:0]  addr_rs1,
  output logic [4:0]  addr_rs2,
  output logic [4:0]  addr_rd,
  output logic        RegWE,
  output logic [31:0] wb_data,
  output logic [31:0] ALU_out,
  output logic        halt
);
  localparam int AW = $clog2(MEM_BYTES);
  logic [31:0] pc_q, pc_d, pc4, imm, op_a, op_b, alu, off, nbytes, rdata, ld_data;
  logic [6:0] opc;
  logic [2:0] f3, alu_f3;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
  logic br_eq, br_lt, taken, in_range;
  logic [AW-1:0] idx;
  logic [7:0] mem [MEM_BYTES];

  assign opc      = instruction[6:0];
  assign f3       = instruction[14:12];
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_br    = opc == 7'b1100011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_opi   = opc == 7'b0010011;
  assign is_op    = opc == 7'b0110011;
  assign halt     = instruction == 32'h0000_0073;
  assign addr_rs1 = instruction[19:15];
  assign addr_rs2 = instruction[24:20];
  assign addr_rd  = instruction[11:7];

  assign imm = is_st ? {{20{instruction[31]}}, instruction[31:25], instruction[11:7]}
             : is_br ? {{20{instruction[31]}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0}
             : (is_lui | is_auipc) ? {instruction[31:12], 12'b0}
             : is_jal ? {{12{instruction[31]}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0}
             : {{20{instruction[31]}}, instruction[31:20]};

  assign op_a   = (is_auipc | is_jal | is_br) ? pc_q : data_rs1;
  assign op_b   = is_op ? data_rs2 : imm;
  assign alu_f3 = (is_op | is_opi) ? f3 : 3'd0;

  // Non-ALU instructions (addresses, branch/jump targets) all use ADD.
  always_comb begin
    case (alu_f3)
      3'd0:    alu = (is_op & instruction[30]) ? op_a - op_b : op_a + op_b;
      3'd1:    alu = op_a << op_b[4:0];
      3'd2:    alu = {31'd0, $signed(op_a) < $signed(op_b)};
      3'd3:    alu = {31'd0, op_a < op_b};
      3'd4:    alu = op_a ^ op_b;
      3'd5:    alu = instruction[30] ? $unsigned($signed(op_a) >>> op_b[4:0]) : op_a >> op_b[4:0];
      3'd6:    alu = op_a | op_b;
      default: alu = op_a & op_b;
    endcase
    if (is_lui) alu = op_b;
  end
  assign ALU_out = alu;

  assign br_eq = data_rs1 == data_rs2;
  assign br_lt = f3[1] ? data_rs1 < data_rs2 : $signed(data_rs1) < $signed(data_rs2);
  assign taken = is_br & (f3[2] ? br_lt ^ f3[0] : ~f3[1] & (br_eq ^ f3[0]));

  // An access is in range only if every byte it touches lies inside the memory.
  assign nbytes   = f3[1] ? 32'd4 : f3[0] ? 32'd2 : 32'd1;
  assign off      = alu - MEM_BASE;
  assign in_range = off <= 32'(MEM_BYTES) - nbytes;
  assign idx      = off[AW-1:0];
  assign rdata    = {mem[idx + AW'(3)], mem[idx + AW'(2)], mem[idx + AW'(1)], mem[idx]};
  assign ld_data  = !in_range ? 32'hBADB_ADFF
                  : f3[1] ? rdata
                  : f3[0] ? {{16{~f3[2] & rdata[15]}}, rdata[15:0]}
                  : {{24{~f3[2] & rdata[7]}}, rdata[7:0]};

  assign pc4 = pc_q + 32'd4;
  always_comb begin
    pc_d = halt ? pc_q : (taken | is_jal) ? alu : is_jalr ? {alu[31:1], 1'b0} : pc4;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= MEM_BASE;
    else        pc_q <= pc_d;

  always_ff @(posedge clk)
    if (rst_n && is_st && in_range) begin
      mem[idx] <= data_rs2[7:0];
      if (f3[1] | f3[0]) mem[idx + AW'(1)] <= data_rs2[15:8];
      if (f3[1]) begin
        mem[idx + AW'(2)] <= data_rs2[23:16];
        mem[idx + AW'(3)] <= data_rs2[31:24];
      end
    end

  assign PC      = pc_q;
  assign PC_next = pc_d;
  assign RegWE   = (is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op) && addr_rd != 5'd0;
  assign wb_data = is_ld ? ld_data : (is_jal | is_jalr) ? pc4 : alu;
endmodule

// File: tb/tb_rv32i_decode_execute_mem.sv
// tb_rv32i_decode_execute_mem: directed and random instruction stream checked every cycle
// against an instruction-level model of the processor state (PC and byte memory).
module tb_rv32i_decode_execute_mem;
  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int          BYTES = 65536;
  localparam logic [31:0] BAD   = 32'hBADB_ADFF;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic [31:0] instruction = 32'h0, data_rs1 = 32'h0, data_rs2 = 32'h0;
  logic [31:0] PC, PC_next, wb_data, ALU_out;
  logic [4:0]  addr_rs1, addr_rs2, addr_rd;
  logic        RegWE, halt;

  rv32i_decode_execute_mem #(.MEM_BASE(BASE), .MEM_BYTES(BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .data_rs1(data_rs1), .data_rs2(data_rs2),
    .PC(PC), .PC_next(PC_next), .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .addr_rd(addr_rd),
    .RegWE(RegWE), .wb_data(wb_data), .ALU_out(ALU_out), .halt(halt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] pc_m, e_next, e_wb, e_alu, e_st_addr, e_st_data;
  logic        e_we, e_chk_alu, e_halt, e_st, chk_en = 1'b0;
  int          e_st_n;
  logic [7:0]  mm [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pc %h instr %h)", nm, act, exp, pc_m, instruction);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic bit in_rng(input logic [31:0] addr, input int n);
    longint o = longint'(addr) - longint'(BASE);
    return o >= 0 && o + n <= BYTES;
  endfunction

  function automatic logic [31:0] alu_calc(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                            input bit sub, input bit sra);
    logic [31:0] r;
    case (f3)
      3'd0: r = sub ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: if (sra) r = $unsigned($signed(a) >>> b[4:0]); else r = a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic bit br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] addr, input logic [2:0] f3);
    int n = f3[1] ? 4 : f3[0] ? 2 : 1;
    logic [31:0] raw = 32'h0;
    if (!in_rng(addr, n)) return BAD;
    for (int i = 0; i < n; i++) raw[8*i +: 8] = mm[int'(addr - BASE) + i];
    case (f3)
      3'd0: return {{24{raw[7]}}, raw[7:0]};
      3'd1: return {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  task automatic model(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [2:0]  f3 = ins[14:12];
    logic [31:0] ii = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    logic [31:0] ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    logic [31:0] iu = {ins[31:12], 12'h0};
    logic [31:0] ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    e_next = pc + 32'd4; e_we = 1'b0; e_wb = 32'h0; e_alu = 32'h0;
    e_chk_alu = 1'b0; e_halt = 1'b0; e_st = 1'b0;
    if (ins == 32'h0000_0073) begin
      e_halt = 1'b1; e_next = pc;
    end else begin
      case (ins[6:0])
        7'h37: begin e_alu = iu; e_we = 1'b1; e_wb = e_alu; e_chk_alu = 1'b1; end
        7'h17: begin e_alu = pc + iu; e_we = 1'b1; e_wb = e_alu; e_chk_alu = 1'b1; end
        7'h6f: begin e_alu = pc + ij; e_next = e_alu; e_we = 1'b1; e_wb = pc + 32'd4; e_chk_alu = 1'b1; end
        7'h67: begin e_alu = a + ii; e_next = e_alu & ~32'd1; e_we = 1'b1; e_wb = pc + 32'd4; e_chk_alu = 1'b1; end
        7'h63: begin e_alu = pc + ib; e_chk_alu = 1'b1; if (br_taken(f3, a, b)) e_next = e_alu; end
        7'h03: begin e_alu = a + ii; e_we = 1'b1; e_wb = mread(e_alu, f3); e_chk_alu = 1'b1; end
        7'h23: begin
          e_alu = a + is; e_chk_alu = 1'b1; e_st = 1'b1; e_st_addr = e_alu; e_st_data = b;
          e_st_n = f3[1] ? 4 : f3[0] ? 2 : 1;
        end
        7'h13: begin e_alu = alu_calc(f3, a, ii, 1'b0, ins[30]); e_we = 1'b1; e_wb = e_alu; e_chk_alu = 1'b1; end
        7'h33: begin e_alu = alu_calc(f3, a, b, ins[30], ins[30]); e_we = 1'b1; e_wb = e_alu; e_chk_alu = 1'b1; end
        default: ;
      endcase
    end
    if (ins[11:7] == 5'd0) e_we = 1'b0;
  endtask

  task automatic commit();
    if (!rst_n) pc_m = BASE;
    else begin
      pc_m = e_next;
      if (e_st && in_rng(e_st_addr, e_st_n))
        for (int i = 0; i < e_st_n; i++) mm[int'(e_st_addr - BASE) + i] = e_st_data[8*i +: 8];
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    instruction = ins; data_rs1 = a; data_rs2 = b;
    model(pc_m, ins, a, b);
    chk_en = 1'b1;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic set_rst(input logic v);
    rst_n = v;
    if (!v) begin
      pc_m = BASE;
      model(pc_m, instruction, data_rs1, data_rs2);
    end
  endtask

  task automatic goto_pc(input logic [31:0] target);
    step(enc_j(target - pc_m, 5'd0), 32'h0, 32'h0);
    next_cycle();
  endtask

  always @(negedge clk)
    if (chk_en) begin
      chk("PC", PC, pc_m);
      chk("PC_next", PC_next, e_next);
      chk("RegWE", {31'd0, RegWE}, {31'd0, e_we});
      chk("halt", {31'd0, halt}, {31'd0, e_halt});
      chk("addr_fields", {17'd0, addr_rs1, addr_rs2, addr_rd},
          {17'd0, instruction[19:15], instruction[24:20], instruction[11:7]});
      if (e_we) chk("wb_data", wb_data, e_wb);
      if (e_chk_alu) chk("ALU_out", ALU_out, e_alu);
    end

  logic [2:0]  lf3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [31:0] lexp [5] = '{32'hFFFF_FF83, 32'h0000_0083, 32'hFFFF_8283, 32'h0000_8283, 32'h8081_8283};
  logic [2:0]  brf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0]  ldf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [6:0]  unk  [5] = '{7'h0F, 7'h7F, 7'h53, 7'h5B, 7'h73};

  initial begin
    logic [31:0] ins, a, b, t, addr, simm;
    logic [4:0]  rd, s1, s2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          n;
    pc_m = BASE;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    step(enc_i(32'hFFF, 5'd0, 3'd0, 5'd5, 7'h13), 32'h0, 32'h0);
    chk("reset_PC", PC, 32'h0100_0000);
    chk("addi_RegWE", {31'd0, RegWE}, 32'd1);
    chk("addi_rd", {27'd0, addr_rd}, 32'd5);
    chk("addi_wb", wb_data, 32'hFFFF_FFFF);
    chk("addi_PC_next", PC_next, 32'h0100_0004);
    #1 rst_n = 1'b1;
    next_cycle();
    for (int k = 0; k < 16; k++) begin
      step(enc_s(32'h0, 5'd2, 5'd1, 3'd2), BASE + 32'h100 + 32'(4 * k), $urandom);
      next_cycle();
    end
    step(enc_s(32'h0, 5'd2, 5'd1, 3'd2), 32'h0100_0100, 32'h8081_8283);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      step(enc_i(32'h0, 5'd1, lf3[i], 5'd3, 7'h03), 32'h0100_0100, 32'h0);
      chk("load_ext", wb_data, lexp[i]);
      next_cycle();
    end
    step(enc_i(32'h0, 5'd1, 3'd2, 5'd3, 7'h03), 32'h0, 32'h0);
    chk("oor_load", wb_data, 32'hBADB_ADFF);
    next_cycle();
    step(enc_s(32'h0, 5'd2, 5'd1, 3'd2), 32'h0000_0100, 32'h1234_5678);
    next_cycle();
    step(enc_i(32'h0, 5'd1, 3'd2, 5'd3, 7'h03), 32'h0100_0100, 32'h0);
    chk("oor_store_ignored", wb_data, 32'h8081_8283);
    next_cycle();
    goto_pc(BASE + 32'h10);
    step(enc_b(-32'sd16, 5'd2, 5'd1, 3'd4), 32'hFFFF_FFFF, 32'h1);
    chk("blt_PC", PC, 32'h0100_0010);
    chk("blt_PC_next", PC_next, 32'h0100_0000);
    next_cycle();
    goto_pc(BASE + 32'h10);
    step(enc_b(-32'sd16, 5'd2, 5'd1, 3'd6), 32'hFFFF_FFFF, 32'h1);
    chk("bltu_PC_next", PC_next, 32'h0100_0014);
    next_cycle();
    goto_pc(BASE + 32'h8);
    step(enc_i(32'd4, 5'd6, 3'd0, 5'd1, 7'h67), 32'h0100_0021, 32'h0);
    chk("jalr_PC_next", PC_next, 32'h0100_0024);
    chk("jalr_wb", wb_data, 32'h0100_000C);
    chk("jalr_RegWE", {31'd0, RegWE}, 32'd1);
    next_cycle();
    goto_pc(BASE + 32'h40);
    for (int i = 0; i < 3; i++) begin
      step(32'h0000_0073, 32'h0, 32'h0);
      chk("ecall_halt", {31'd0, halt}, 32'd1);
      chk("ecall_RegWE", {31'd0, RegWE}, 32'd0);
      chk("ecall_PC", PC, 32'h0100_0040);
      next_cycle();
    end
    step(enc_s(32'h0, 5'd2, 5'd1, 3'd2), 32'h0100_0100, 32'hDEAD_BEEF);
    chk("after_ecall_PC", PC, 32'h0100_0040);
    set_rst(1'b0);
    #1 chk("mid_reset_PC", PC, 32'h0100_0000);
    next_cycle();
    step(32'h0000_0013, 32'h0, 32'h0);
    #1 set_rst(1'b1);
    next_cycle();
    step(enc_i(32'h0, 5'd1, 3'd2, 5'd3, 7'h03), 32'h0100_0100, 32'h0);
    chk("store_aborted", wb_data, 32'h8081_8283);
    next_cycle();
    for (int it = 0; it < 600; it++) begin
      t = $urandom; a = $urandom; b = $urandom;
      rd = 5'($urandom_range(0, 31)); s1 = 5'($urandom_range(0, 31)); s2 = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 19))
        0, 1: ins = {t[31:12], rd, 7'h37};
        2:    ins = {t[31:12], rd, 7'h17};
        3:    ins = {t[31:12], rd, 7'h6f};
        4:    ins = {t[31:20], s1, 3'd0, rd, 7'h67};
        5, 6: begin
          if ($urandom_range(0, 3) == 0) b = a;
          ins = {t[31:25], s2, s1, brf3[$urandom_range(0, 5)], t[11:7], 7'h63};
        end
        7, 8: begin
          f3 = ldf3[$urandom_range(0, 4)];
          n = f3[1] ? 4 : f3[0] ? 2 : 1;
          if ($urandom_range(0, 7) == 0) begin
            if (t[1]) begin addr = BASE + 32'(BYTES) - 32'd2; f3 = 3'd2; end
            else addr = 32'($urandom_range(0, 32'h00FF_0000));
          end else addr = BASE + 32'h100 + 32'($urandom_range(0, 64 - n));
          simm = {{20{t[31]}}, t[31:20]};
          a = addr - simm;
          ins = {t[31:20], s1, f3, rd, 7'h03};
        end
        9, 10: begin
          f3 = 3'($urandom_range(0, 2));
          n = f3[1] ? 4 : f3[0] ? 2 : 1;
          if ($urandom_range(0, 7) == 0) begin
            if (t[1]) begin addr = BASE + 32'(BYTES) - 32'd1; f3 = 3'd2; end
            else addr = 32'($urandom_range(0, 32'h00FF_0000));
          end else addr = BASE + 32'h100 + 32'($urandom_range(0, 64 - n));
          simm = {{20{t[31]}}, t[31:25], t[11:7]};
          a = addr - simm;
          ins = {t[31:25], s2, s1, f3, t[11:7], 7'h23};
        end
        11, 12, 13: begin
          f3 = 3'($urandom_range(0, 7));
          f7 = t[31:25];
          if (f3 == 3'd1) f7 = 7'h00;
          if (f3 == 3'd5) f7 = t[0] ? 7'h20 : 7'h00;
          ins = {f7, t[24:20], s1, f3, rd, 7'h13};
        end
        14, 15, 16: begin
          f3 = 3'($urandom_range(0, 7));
          f7 = ((f3 == 3'd0 || f3 == 3'd5) && t[0]) ? 7'h20 : 7'h00;
          ins = {f7, s2, s1, f3, rd, 7'h33};
        end
        17, 18: begin
          ins = {t[31:7], unk[$urandom_range(0, 4)]};
          if (ins == 32'h0000_0073) ins[20] = 1'b1;
        end
        default: ins = 32'h0000_0073;
      endcase
      step(ins, a, b);
      next_cycle();
    end
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
